// File: rtl/s32x_fb_ctrl_pkg.sv
// rtl/s32x_fb_ctrl_pkg.sv - shared types and helpers for the 32X framebuffer controller
// Purpose: request slot layout, controller state encoding and the channel pick helper.
package s32x_fb_ctrl_pkg;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } FBREQ_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } FBCTRL_STATE_t;

    localparam logic [1:0] BE_ALL = 2'b11;

    // Choose a channel among pending ones; the pointer only matters when both are pending.
    function automatic logic pick_chan(input logic [1:0] pend, input logic rr);
        if (&pend) begin
            return rr;
        end
        return pend[1];
    endfunction

endpackage

// File: rtl/s32x_fb_chan.sv
// rtl/s32x_fb_chan.sv - per-channel strobe edge detect, request slots and overrun flag
// Purpose: turns VDP read/write strobes into one pending read and one pending write slot.
// Ports:
//   CLK, RST_N         clock, asynchronous active-low reset
//   fb_a/fb_do/fb_we   VDP address, write data, byte write enables
//   fb_rd              VDP read strobe
//   clr_rd/clr_wr      arbiter grant: empties the corresponding slot this cycle
//   rd_pend/rd_slot    pending read and its request
//   wr_pend/wr_slot    pending write and its request
//   ovr                sticky overrun flag
module s32x_fb_chan
    import s32x_fb_ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] fb_a,
    input  logic [15:0] fb_do,
    input  logic [1:0]  fb_we,
    input  logic        fb_rd,
    input  logic        clr_rd,
    input  logic        clr_wr,
    output logic        rd_pend,
    output FBREQ_t      rd_slot,
    output logic        wr_pend,
    output FBREQ_t      wr_slot,
    output logic        ovr
);

    logic   rd_prev_q, rd_prev_d;
    logic   we_prev_q, we_prev_d;
    logic   rd_pend_q, rd_pend_d;
    logic   wr_pend_q, wr_pend_d;
    FBREQ_t rd_slot_q, rd_slot_d;
    FBREQ_t wr_slot_q, wr_slot_d;
    logic   ovr_q, ovr_d;
    logic   rd_edge, wr_edge;

    always_comb begin
        rd_edge   = fb_rd && !rd_prev_q;
        wr_edge   = (|fb_we) && !we_prev_q;
        rd_prev_d = fb_rd;
        we_prev_d = |fb_we;
        rd_pend_d = rd_pend_q && !clr_rd;
        wr_pend_d = wr_pend_q && !clr_wr;
        rd_slot_d = rd_slot_q;
        wr_slot_d = wr_slot_q;
        ovr_d     = ovr_q;
        // A slot that is being granted this cycle is free, so a new edge there is not an overrun.
        if (rd_edge) begin
            if (rd_pend_q && !clr_rd) begin
                ovr_d = 1'b1;
            end
            rd_pend_d      = 1'b1;
            rd_slot_d.addr = fb_a;
            rd_slot_d.data = 16'h0000;
            rd_slot_d.be   = BE_ALL;
        end
        if (wr_edge) begin
            if (wr_pend_q && !clr_wr) begin
                ovr_d = 1'b1;
            end
            wr_pend_d      = 1'b1;
            wr_slot_d.addr = fb_a;
            wr_slot_d.data = fb_do;
            wr_slot_d.be   = fb_we;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_prev_q <= 1'b0;
            we_prev_q <= 1'b0;
            rd_pend_q <= 1'b0;
            wr_pend_q <= 1'b0;
            rd_slot_q <= '0;
            wr_slot_q <= '0;
            ovr_q     <= 1'b0;
        end else begin
            rd_prev_q <= rd_prev_d;
            we_prev_q <= we_prev_d;
            rd_pend_q <= rd_pend_d;
            wr_pend_q <= wr_pend_d;
            rd_slot_q <= rd_slot_d;
            wr_slot_q <= wr_slot_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rd_pend = rd_pend_q;
    assign wr_pend = wr_pend_q;
    assign rd_slot = rd_slot_q;
    assign wr_slot = wr_slot_q;
    assign ovr     = ovr_q;

endmodule

// File: rtl/s32x_fb_ctrl.sv
// rtl/s32x_fb_ctrl.sv - two-port VDP framebuffer controller on one shared word memory
// Purpose: queues FB0/FB1 accesses, arbitrates reads over writes, runs req/ack memory cycles.
// Ports:
//   CLK, RST_N                      clock, asynchronous active-low reset
//   FBn_A/FBn_DO/FBn_WE/FBn_RD      VDP channel n request inputs
//   FBn_DI                          VDP channel n read data, held between reads
//   MEM_A/MEM_D/MEM_BE/MEM_WE       memory cycle, stable while MEM_REQ is high
//   MEM_REQ/MEM_ACK/MEM_Q           request, one-cycle completion, read data
//   OVR                             sticky per-channel overrun flags
module s32x_fb_ctrl
    import s32x_fb_ctrl_pkg::*;
#(
    parameter bit BANK_SWAP = 1'b0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] FB0_A,
    input  logic [15:0] FB0_DO,
    output logic [15:0] FB0_DI,
    input  logic [1:0]  FB0_WE,
    input  logic        FB0_RD,
    input  logic [15:0] FB1_A,
    input  logic [15:0] FB1_DO,
    output logic [15:0] FB1_DI,
    input  logic [1:0]  FB1_WE,
    input  logic        FB1_RD,
    output logic [16:0] MEM_A,
    output logic [15:0] MEM_D,
    output logic [1:0]  MEM_BE,
    output logic        MEM_WE,
    output logic        MEM_REQ,
    input  logic        MEM_ACK,
    input  logic [15:0] MEM_Q,
    output logic [1:0]  OVR
);

    logic [1:0] rd_pend, wr_pend, clr_rd, clr_wr, ovr_w;
    FBREQ_t     rd_slot [2];
    FBREQ_t     wr_slot [2];

    s32x_fb_chan u_chan0 (
        .CLK(CLK), .RST_N(RST_N), .fb_a(FB0_A), .fb_do(FB0_DO), .fb_we(FB0_WE), .fb_rd(FB0_RD),
        .clr_rd(clr_rd[0]), .clr_wr(clr_wr[0]), .rd_pend(rd_pend[0]), .rd_slot(rd_slot[0]),
        .wr_pend(wr_pend[0]), .wr_slot(wr_slot[0]), .ovr(ovr_w[0])
    );

    s32x_fb_chan u_chan1 (
        .CLK(CLK), .RST_N(RST_N), .fb_a(FB1_A), .fb_do(FB1_DO), .fb_we(FB1_WE), .fb_rd(FB1_RD),
        .clr_rd(clr_rd[1]), .clr_wr(clr_wr[1]), .rd_pend(rd_pend[1]), .rd_slot(rd_slot[1]),
        .wr_pend(wr_pend[1]), .wr_slot(wr_slot[1]), .ovr(ovr_w[1])
    );

    FBCTRL_STATE_t state_q, state_d;
    logic          rr_q, rr_d;
    logic          cur_ch_q, cur_ch_d;
    logic [16:0]   mem_a_q, mem_a_d;
    logic [15:0]   mem_d_q, mem_d_d;
    logic [1:0]    mem_be_q, mem_be_d;
    logic          mem_we_q, mem_we_d;
    logic          mem_req_q, mem_req_d;
    logic [15:0]   fb0_di_q, fb0_di_d;
    logic [15:0]   fb1_di_q, fb1_di_d;
    logic          gnt_rd, gnt_ch;
    FBREQ_t        gnt_slot;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        cur_ch_d  = cur_ch_q;
        mem_a_d   = mem_a_q;
        mem_d_d   = mem_d_q;
        mem_be_d  = mem_be_q;
        mem_we_d  = mem_we_q;
        mem_req_d = mem_req_q;
        fb0_di_d  = fb0_di_q;
        fb1_di_d  = fb1_di_q;
        clr_rd    = 2'b00;
        clr_wr    = 2'b00;
        // Reads always win over writes; a channel with both pending therefore reads first.
        gnt_rd    = |rd_pend;
        gnt_ch    = gnt_rd ? pick_chan(rd_pend, rr_q) : pick_chan(wr_pend, rr_q);
        gnt_slot  = gnt_rd ? rd_slot[gnt_ch] : wr_slot[gnt_ch];
        case (state_q)
            IDLE: begin
                if ((|rd_pend) || (|wr_pend)) begin
                    state_d         = BUSY;
                    rr_d            = ~rr_q;
                    cur_ch_d        = gnt_ch;
                    mem_a_d         = {gnt_ch ^ BANK_SWAP, gnt_slot.addr};
                    mem_d_d         = gnt_slot.data;
                    mem_be_d        = gnt_rd ? BE_ALL : gnt_slot.be;
                    mem_we_d        = !gnt_rd;
                    mem_req_d       = 1'b1;
                    clr_rd[gnt_ch]  = gnt_rd;
                    clr_wr[gnt_ch]  = !gnt_rd;
                end
            end
            BUSY: begin
                if (MEM_ACK) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        if (cur_ch_q) begin
                            fb1_di_d = MEM_Q;
                        end else begin
                            fb0_di_d = MEM_Q;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            cur_ch_q  <= 1'b0;
            mem_a_q   <= '0;
            mem_d_q   <= '0;
            mem_be_q  <= '0;
            mem_we_q  <= 1'b0;
            mem_req_q <= 1'b0;
            fb0_di_q  <= '0;
            fb1_di_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            cur_ch_q  <= cur_ch_d;
            mem_a_q   <= mem_a_d;
            mem_d_q   <= mem_d_d;
            mem_be_q  <= mem_be_d;
            mem_we_q  <= mem_we_d;
            mem_req_q <= mem_req_d;
            fb0_di_q  <= fb0_di_d;
            fb1_di_q  <= fb1_di_d;
        end
    end

    assign MEM_A   = mem_a_q;
    assign MEM_D   = mem_d_q;
    assign MEM_BE  = mem_be_q;
    assign MEM_WE  = mem_we_q;
    assign MEM_REQ = mem_req_q;
    assign FB0_DI  = fb0_di_q;
    assign FB1_DI  = fb1_di_q;
    assign OVR     = ovr_w;

endmodule

// File: tb/tb_s32x_fb_ctrl.sv
// tb/tb_s32x_fb_ctrl.sv - directed self-checking bench for s32x_fb_ctrl
module tb_s32x_fb_ctrl;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] FB0_A, FB0_DO, FB1_A, FB1_DO, MEM_Q;
    logic [1:0]  FB0_WE, FB1_WE;
    logic        FB0_RD, FB1_RD, MEM_ACK;
    logic [15:0] FB0_DI, FB1_DI, MEM_D;
    logic [16:0] MEM_A;
    logic [1:0]  MEM_BE, OVR;
    logic        MEM_WE, MEM_REQ;

    logic [15:0] sw_fb0_a, sw_q;
    logic        sw_fb0_rd, sw_ack;
    logic [15:0] sw_fb0_di, sw_fb1_di, sw_mem_d;
    logic [16:0] sw_mem_a;
    logic [1:0]  sw_mem_be, sw_ovr;
    logic        sw_mem_we, sw_mem_req;

    int checks = 0;
    int errors = 0;

    logic [16:0] log_a  [$];
    logic        log_we [$];
    logic [1:0]  log_be [$];
    logic [15:0] log_d  [$];
    int          log_cyc[$];

    always #5 CLK = ~CLK;

    s32x_fb_ctrl dut (
        .CLK(CLK), .RST_N(RST_N),
        .FB0_A(FB0_A), .FB0_DO(FB0_DO), .FB0_DI(FB0_DI), .FB0_WE(FB0_WE), .FB0_RD(FB0_RD),
        .FB1_A(FB1_A), .FB1_DO(FB1_DO), .FB1_DI(FB1_DI), .FB1_WE(FB1_WE), .FB1_RD(FB1_RD),
        .MEM_A(MEM_A), .MEM_D(MEM_D), .MEM_BE(MEM_BE), .MEM_WE(MEM_WE), .MEM_REQ(MEM_REQ),
        .MEM_ACK(MEM_ACK), .MEM_Q(MEM_Q), .OVR(OVR)
    );

    s32x_fb_ctrl #(.BANK_SWAP(1'b1)) dut_sw (
        .CLK(CLK), .RST_N(RST_N),
        .FB0_A(sw_fb0_a), .FB0_DO(16'h0000), .FB0_DI(sw_fb0_di), .FB0_WE(2'b00), .FB0_RD(sw_fb0_rd),
        .FB1_A(16'h0000), .FB1_DO(16'h0000), .FB1_DI(sw_fb1_di), .FB1_WE(2'b00), .FB1_RD(1'b0),
        .MEM_A(sw_mem_a), .MEM_D(sw_mem_d), .MEM_BE(sw_mem_be), .MEM_WE(sw_mem_we), .MEM_REQ(sw_mem_req),
        .MEM_ACK(sw_ack), .MEM_Q(sw_q), .OVR(sw_ovr)
    );

    task automatic do_reset;
        RST_N = 1'b0;
        FB0_A = '0; FB0_DO = '0; FB0_WE = '0; FB0_RD = 1'b0;
        FB1_A = '0; FB1_DO = '0; FB1_WE = '0; FB1_RD = 1'b0;
        MEM_ACK = 1'b0; MEM_Q = '0;
        sw_fb0_a = '0; sw_fb0_rd = 1'b0; sw_ack = 1'b0; sw_q = '0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic clear_log;
        log_a.delete(); log_we.delete(); log_be.delete(); log_d.delete(); log_cyc.delete();
    endtask

    // Memory model: records each new request and acknowledges it after dly extra cycles.
    task automatic run_mem(input int cycles, input int dly, input logic [15:0] q);
        int held = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            if (MEM_ACK) begin
                MEM_ACK = 1'b0;
                held = 0;
            end else if (MEM_REQ) begin
                if (held == 0) begin
                    log_a.push_back(MEM_A); log_we.push_back(MEM_WE);
                    log_be.push_back(MEM_BE); log_d.push_back(MEM_D); log_cyc.push_back(i);
                end
                if (held >= dly) begin
                    MEM_ACK = 1'b1;
                    MEM_Q = q;
                end
                held++;
            end
        end
        @(negedge CLK);
        MEM_ACK = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if ({MEM_REQ, MEM_WE, MEM_A, MEM_D, MEM_BE, OVR, FB0_DI, FB1_DI} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b we=%b a=%h d=%h be=%b ovr=%b di0=%h di1=%h, expected all zero",
                     MEM_REQ, MEM_WE, MEM_A, MEM_D, MEM_BE, OVR, FB0_DI, FB1_DI);
        end
    endtask

    task automatic test_single_read;
        do_reset;
        clear_log;
        FB0_A = 16'h1234;
        FB0_RD = 1'b1;
        fork
            begin @(negedge CLK); FB0_RD = 1'b0; end
            run_mem(8, 0, 16'hBEEF);
        join
        checks++;
        if (log_a.size() != 1) begin
            errors++;
            $display("FAIL read_count: got %0d expected 1", log_a.size());
        end else begin
            checks++;
            if ({log_we[0], log_be[0], log_a[0]} !== {1'b0, 2'b11, 17'h01234}) begin
                errors++;
                $display("FAIL read_fields: got we=%b be=%b a=%h expected we=0 be=11 a=01234",
                         log_we[0], log_be[0], log_a[0]);
            end
            checks++;
            if (log_cyc[0] != 1) begin
                errors++;
                $display("FAIL read_latency: req seen at cycle %0d expected 1", log_cyc[0]);
            end
        end
        checks++;
        if (FB0_DI !== 16'hBEEF) begin
            errors++;
            $display("FAIL read_fb0_di: got %h expected beef", FB0_DI);
        end
        checks++;
        if (FB1_DI !== 16'h0000) begin
            errors++;
            $display("FAIL read_fb1_di_held: got %h expected 0000", FB1_DI);
        end
    endtask

    task automatic test_held_write;
        clear_log;
        FB1_A = 16'h0010; FB1_DO = 16'h00AA; FB1_WE = 2'b01;
        fork
            begin repeat (6) @(negedge CLK); FB1_WE = 2'b00; end
            run_mem(16, 1, 16'h0000);
        join
        checks++;
        if (log_a.size() != 1) begin
            errors++;
            $display("FAIL held_write_count: got %0d expected 1", log_a.size());
        end else begin
            checks++;
            if ({log_we[0], log_be[0], log_a[0], log_d[0]} !== {1'b1, 2'b01, 17'h10010, 16'h00AA}) begin
                errors++;
                $display("FAIL held_write_fields: got we=%b be=%b a=%h d=%h expected we=1 be=01 a=10010 d=00aa",
                         log_we[0], log_be[0], log_a[0], log_d[0]);
            end
        end
    endtask

    task automatic test_read_beats_write;
        clear_log;
        FB0_A = 16'h0020; FB0_DO = 16'h5555; FB0_WE = 2'b11;
        FB1_A = 16'h0030; FB1_RD = 1'b1;
        fork
            begin @(negedge CLK); FB0_WE = 2'b00; FB1_RD = 1'b0; end
            run_mem(20, 1, 16'hC0DE);
        join
        checks++;
        if (log_a.size() != 2) begin
            errors++;
            $display("FAIL prio_count: got %0d expected 2", log_a.size());
        end else begin
            checks++;
            if ({log_we[0], log_a[0], log_we[1], log_be[1], log_a[1], log_d[1]} !==
                {1'b0, 17'h10030, 1'b1, 2'b11, 17'h00020, 16'h5555}) begin
                errors++;
                $display("FAIL prio_order: got [we=%b a=%h] [we=%b be=%b a=%h d=%h] expected [0 10030] [1 11 00020 5555]",
                         log_we[0], log_a[0], log_we[1], log_be[1], log_a[1], log_d[1]);
            end
        end
        checks++;
        if (FB1_DI !== 16'hC0DE) begin
            errors++;
            $display("FAIL prio_fb1_di: got %h expected c0de", FB1_DI);
        end
    endtask

    task automatic test_round_robin;
        do_reset;
        clear_log;
        FB0_A = 16'h0100; FB1_A = 16'h0200; FB0_RD = 1'b1; FB1_RD = 1'b1;
        fork
            begin @(negedge CLK); FB0_RD = 1'b0; FB1_RD = 1'b0; end
            run_mem(12, 0, 16'h0001);
        join
        FB1_A = 16'h0300; FB1_RD = 1'b1;
        fork
            begin @(negedge CLK); FB1_RD = 1'b0; end
            run_mem(8, 0, 16'h0002);
        join
        FB0_A = 16'h0400; FB1_A = 16'h0500; FB0_RD = 1'b1; FB1_RD = 1'b1;
        fork
            begin @(negedge CLK); FB0_RD = 1'b0; FB1_RD = 1'b0; end
            run_mem(12, 0, 16'h0003);
        join
        checks++;
        if (log_a.size() != 5) begin
            errors++;
            $display("FAIL rr_count: got %0d expected 5", log_a.size());
        end else begin
            checks++;
            if ({log_a[0], log_a[1], log_a[2], log_a[3], log_a[4]} !==
                {17'h00100, 17'h10200, 17'h10300, 17'h10500, 17'h00400}) begin
                errors++;
                $display("FAIL rr_order: got %h %h %h %h %h expected 00100 10200 10300 10500 00400",
                         log_a[0], log_a[1], log_a[2], log_a[3], log_a[4]);
            end
        end
    endtask

    task automatic test_overrun;
        do_reset;
        clear_log;
        FB1_A = 16'h0040; FB1_RD = 1'b1;
        fork
            begin
                for (int j = 0; j < 6; j++) begin
                    @(negedge CLK);
                    case (j)
                        0: FB1_RD = 1'b0;
                        2: begin FB0_A = 16'h0001; FB0_RD = 1'b1; end
                        3: FB0_RD = 1'b0;
                        4: begin FB0_A = 16'h0002; FB0_RD = 1'b1; end
                        5: FB0_RD = 1'b0;
                        default: ;
                    endcase
                end
            end
            run_mem(30, 8, 16'h7777);
        join
        checks++;
        if (log_a.size() != 2) begin
            errors++;
            $display("FAIL ovr_count: got %0d expected 2", log_a.size());
        end else begin
            checks++;
            if ({log_a[0], log_a[1]} !== {17'h10040, 17'h00002}) begin
                errors++;
                $display("FAIL ovr_addrs: got %h %h expected 10040 00002", log_a[0], log_a[1]);
            end
        end
        checks++;
        if (OVR !== 2'b01) begin
            errors++;
            $display("FAIL ovr_flag: got %b expected 01", OVR);
        end
        checks++;
        if (FB0_DI !== 16'h7777) begin
            errors++;
            $display("FAIL ovr_fb0_di: got %h expected 7777", FB0_DI);
        end
    endtask

    task automatic test_grant_collision;
        do_reset;
        clear_log;
        FB1_A = 16'h0050; FB1_RD = 1'b1;
        fork
            begin
                for (int j = 0; j < 8; j++) begin
                    @(negedge CLK);
                    case (j)
                        0: FB1_RD = 1'b0;
                        1: begin FB0_A = 16'h0007; FB0_RD = 1'b1; end
                        2: FB0_RD = 1'b0;
                        6: begin FB0_A = 16'h0008; FB0_RD = 1'b1; end
                        7: FB0_RD = 1'b0;
                        default: ;
                    endcase
                end
            end
            run_mem(30, 4, 16'h1111);
        join
        checks++;
        if (log_a.size() != 3) begin
            errors++;
            $display("FAIL collide_count: got %0d expected 3", log_a.size());
        end else begin
            checks++;
            if ({log_a[0], log_a[1], log_a[2]} !== {17'h10050, 17'h00007, 17'h00008}) begin
                errors++;
                $display("FAIL collide_addrs: got %h %h %h expected 10050 00007 00008",
                         log_a[0], log_a[1], log_a[2]);
            end
        end
        checks++;
        if (OVR !== 2'b00) begin
            errors++;
            $display("FAIL collide_ovr: got %b expected 00", OVR);
        end
    endtask

    task automatic test_bank_swap;
        do_reset;
        sw_fb0_a = 16'h0000;
        sw_fb0_rd = 1'b1;
        @(negedge CLK);
        sw_fb0_rd = 1'b0;
        @(negedge CLK);
        checks++;
        if ({sw_mem_req, sw_mem_we, sw_mem_a} !== {1'b1, 1'b0, 17'h10000}) begin
            errors++;
            $display("FAIL swap_req: got req=%b we=%b a=%h expected req=1 we=0 a=10000",
                     sw_mem_req, sw_mem_we, sw_mem_a);
        end
        sw_ack = 1'b1;
        sw_q = 16'hABCD;
        @(negedge CLK);
        sw_ack = 1'b0;
        checks++;
        if ({sw_mem_req, sw_fb0_di, sw_fb1_di} !== {1'b0, 16'hABCD, 16'h0000}) begin
            errors++;
            $display("FAIL swap_data: got req=%b di0=%h di1=%h expected req=0 di0=abcd di1=0000",
                     sw_mem_req, sw_fb0_di, sw_fb1_di);
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        FB0_A = 16'h0060; FB0_RD = 1'b1;
        FB1_A = 16'h0061; FB1_DO = 16'h1234; FB1_WE = 2'b11;
        @(negedge CLK);
        FB0_RD = 1'b0; FB1_WE = 2'b00;
        @(negedge CLK);
        checks++;
        if (MEM_REQ !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre_req: got %b expected 1", MEM_REQ);
        end
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if ({MEM_REQ, MEM_A} !== {1'b0, 17'h00000}) begin
            errors++;
            $display("FAIL midrst_async: got req=%b a=%h expected req=0 a=00000", MEM_REQ, MEM_A);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        clear_log;
        run_mem(12, 0, 16'h0000);
        checks++;
        if (log_a.size() != 0) begin
            errors++;
            $display("FAIL midrst_stale: got %0d requests expected 0", log_a.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single_read;
        test_held_write;
        test_read_beats_write;
        test_round_robin;
        test_overrun;
        test_grant_collision;
        test_bank_swap;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
